// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the core (C) and an
// external debug/DMA master (E); one access per three enabled cycles.
module sram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter bit CORE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clk_valid,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_write_en,
  input  logic [DATA_W-1:0] sram_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state;
  logic   owner_c;  // owner of the current/last access: 1 = core, 0 = external
  logic   we_q;
  logic   pick_c;

  // Under contention the port that did not own the previous access wins.
  assign pick_c = c_req && (!e_req || !owner_c);

  // NOTE: all state is non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state           <= IDLE;
      owner_c         <= !CORE_FIRST;
      we_q            <= 1'b0;
      c_gnt           <= 1'b0;
      e_gnt           <= 1'b0;
      c_rvalid        <= 1'b0;
      e_rvalid        <= 1'b0;
      rdata           <= '0;
      sram_addr       <= '0;
      sram_write_data <= '0;
      sram_write_en   <= 1'b0;
      busy            <= 1'b0;
    end else if (clk_valid) begin
      c_gnt    <= 1'b0;
      e_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || e_req) begin
            owner_c         <= pick_c;
            we_q            <= pick_c ? c_we    : e_we;
            sram_addr       <= pick_c ? c_addr  : e_addr;
            sram_write_data <= pick_c ? c_wdata : e_wdata;
            c_gnt           <= pick_c;
            e_gnt           <= !pick_c;
            busy            <= 1'b1;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          sram_write_en <= we_q;
          state         <= DONE;
        end
        DONE: begin
          sram_write_en <= 1'b0;
          busy          <= 1'b0;
          if (!we_q) begin
            rdata    <= sram_read_data;
            c_rvalid <= owner_c;
            e_rvalid <= !owner_c;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: timeline-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       clk_valid = 1'b1;
  logic       c_req = 1'b0, c_we = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [7:0] c_addr = '0, c_wdata = '0, e_addr = '0, e_wdata = '0;
  logic       c_gnt, c_rvalid, e_gnt, e_rvalid, sram_write_en, busy;
  logic [7:0] rdata, sram_addr, sram_write_data, sram_read_data;

  int passed = 0;
  int total  = 0;

  sram_arbiter dut (
    .clk(clk), .arst_n(arst_n), .clk_valid(clk_valid),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid),
    .rdata(rdata), .sram_addr(sram_addr), .sram_write_data(sram_write_data),
    .sram_write_en(sram_write_en), .sram_read_data(sram_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM macro: combinational read, write on any clock edge the strobe is high.
  logic [7:0] sram [256];
  assign sram_read_data = sram[sram_addr];
  always @(posedge clk) if (sram_write_en) sram[sram_addr] <= sram_write_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: counts enabled edges and derives every output from the
  // edge index of the most recent grant.
  int         k = 0, g = 0;
  bit         have_g = 0, g_c = 0, g_we = 0, last_c = 0;
  logic [7:0] g_rd = '0, m_rdata = '0, m_addr = '0, m_wdata = '0;
  logic [7:0] mem [256];

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      k = 0; have_g = 0; last_c = 0;
      m_rdata = '0; m_addr = '0; m_wdata = '0;
    end else if (clk_valid) begin
      k++;
      if (have_g && k == g + 2 && !g_we) m_rdata = g_rd;
      if ((!have_g || k >= g + 3) && (c_req || e_req)) begin
        g_c     = (c_req && e_req) ? !last_c : c_req;
        last_c  = g_c;
        g_we    = g_c ? c_we : e_we;
        m_addr  = g_c ? c_addr : e_addr;
        m_wdata = g_c ? c_wdata : e_wdata;
        g_rd    = mem[m_addr];
        if (g_we) mem[m_addr] = m_wdata;
        g       = k;
        have_g  = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      check("c_gnt",    32'(c_gnt),    32'(have_g && k == g && g_c));
      check("e_gnt",    32'(e_gnt),    32'(have_g && k == g && !g_c));
      check("wr_en",    32'(sram_write_en), 32'(have_g && k == g + 1 && g_we));
      check("c_rvalid", 32'(c_rvalid), 32'(have_g && k == g + 2 && !g_we && g_c));
      check("e_rvalid", 32'(e_rvalid), 32'(have_g && k == g + 2 && !g_we && !g_c));
      check("busy",     32'(busy),     32'(have_g && (k == g || k == g + 1)));
      check("sram_addr",  32'(sram_addr),       32'(m_addr));
      check("sram_wdata", 32'(sram_write_data), 32'(m_wdata));
      check("rdata",      32'(rdata),           32'(m_rdata));
      check("excl", 32'((c_gnt && e_gnt) || (c_rvalid && e_rvalid)), 32'd0);
    end
  end

  task automatic drive_req(input bit port_c, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata);
    bit got = 0;
    int cnt = 0;
    if (port_c) begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; end
    else        begin e_req = 1; e_we = we; e_addr = addr; e_wdata = wdata; end
    while (!got && cnt < 20) begin
      @(negedge clk);
      cnt++;
      got = port_c ? c_gnt : e_gnt;
    end
    c_req = 0;
    e_req = 0;
    check("gnt_wait", 32'(got), 32'd1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({c_gnt, e_gnt, c_rvalid, e_rvalid, sram_write_en, busy,
                rdata, sram_addr, sram_write_data});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit order [4];
    int cyc [4];
    int n;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 8'(i) ^ 8'h5A;
      mem[i]  = 8'(i) ^ 8'h5A;
    end
    sram[255] = 8'h3C;
    mem[255]  = 8'h3C;

    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    arst_n = 1;
    @(negedge clk);

    // Core write 0x05 <= 0xA5
    drive_req(1, 1, 8'h05, 8'hA5);
    check("wr_gnt", 32'({c_gnt, e_gnt, busy}), 32'b101);
    @(negedge clk);
    check("wr_strobe", 32'({sram_write_en, sram_addr, sram_write_data}), {15'd0, 1'b1, 8'h05, 8'hA5});
    @(negedge clk);
    check("wr_no_rvalid", 32'({c_rvalid, sram_write_en}), 32'd0);

    // Core read 0x05 -> 0xA5
    drive_req(1, 0, 8'h05, 8'h00);
    repeat (2) @(negedge clk);
    check("rd_rvalid", 32'(c_rvalid), 32'd1);
    check("rd_data", 32'(rdata), 32'hA5);
    @(negedge clk);

    // Contention held from reset: expect C,E,C,E three enabled cycles apart
    arst_n = 0;
    c_req = 1; c_we = 0; c_addr = 8'h05;
    e_req = 1; e_we = 0; e_addr = 8'h06;
    @(negedge clk);
    arst_n = 1;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (c_gnt || e_gnt) begin
        order[n] = c_gnt;
        cyc[n]   = i;
        n++;
      end
    end
    c_req = 0;
    e_req = 0;
    check("contention_count", 32'(n), 32'd4);
    check("contention_order", 32'({order[0], order[1], order[2], order[3]}), 32'b1010);
    for (int i = 1; i < 4; i++) check("contention_gap", 32'(cyc[i] - cyc[i-1]), 32'd3);
    repeat (3) @(negedge clk);

    // Clock-enable stretch: write 0x20 <= 0x77 with enable 1,0,0,1
    drive_req(1, 1, 8'h20, 8'h77);
    clk_valid = 0;
    repeat (2) @(negedge clk);
    check("stretch_gnt", 32'({c_gnt, sram_write_en}), 32'b10);
    clk_valid = 1;
    @(negedge clk);
    check("stretch_strobe", 32'({c_gnt, sram_write_en}), 32'b01);
    clk_valid = 0;
    @(negedge clk);
    check("stretch_strobe_hold", 32'(sram_write_en), 32'd1);
    clk_valid = 1;
    @(negedge clk);
    check("stretch_done", 32'({sram_write_en, c_rvalid}), 32'd0);
    drive_req(1, 0, 8'h20, 8'h00);
    repeat (2) @(negedge clk);
    clk_valid = 0;
    repeat (2) @(negedge clk);
    check("stretch_rvalid", 32'({c_rvalid, rdata}), {23'd0, 1'b1, 8'h77});
    clk_valid = 1;
    @(negedge clk);
    check("stretch_rvalid_end", 32'(c_rvalid), 32'd0);

    // Reset during the strobe of a write to 0x10
    drive_req(1, 1, 8'h10, 8'h99);
    @(negedge clk);
    check("abort_strobe_before", 32'(sram_write_en), 32'd1);
    #2 arst_n = 0;
    #1 check("abort_async_en", 32'(sram_write_en), 32'd0);
    check("abort_outputs", all_outs(), 32'd0);
    @(negedge clk);
    arst_n = 1;
    drive_req(0, 1, 8'h30, 8'h42);
    check("post_reset_gnt", 32'({e_gnt, c_gnt, sram_addr}), {22'd0, 2'b10, 8'h30});
    repeat (2) @(negedge clk);
    drive_req(0, 0, 8'h30, 8'h00);
    repeat (2) @(negedge clk);
    check("post_reset_read", 32'({e_rvalid, rdata}), {23'd0, 1'b1, 8'h42});

    // External read of 0xFF returns 0x3C
    @(negedge clk);
    drive_req(0, 0, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);
    check("ext_read", 32'({e_rvalid, c_rvalid, rdata}), {22'd0, 2'b10, 8'h3C});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
